// File: rtl/if_id_stage.sv
// IF/ID pipeline register: holds {pc, instr} plus the extracted immediate and sign-extend opcode.
// Optional one-entry skid buffer (registered in_ready) when IF_ID_SKID_EN is defined.
module if_id_stage #(
   parameter int XLEN  = 32,
   parameter int IMM_W = 24
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [XLEN-1:0]  in_instr,
   input  logic [XLEN-1:0]  in_pc,
   input  logic             flush,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [XLEN-1:0]  out_instr,
   output logic [XLEN-1:0]  out_pc,
   output logic [IMM_W-1:0] out_imm,
   output logic [1:0]       out_extop
);

   // 2'b10: 24-bit branch offset, 2'b00: 16-bit zero-extend, 2'b01: 16-bit sign-extend
   function automatic logic [1:0] extop_decode(input logic [3:0] op);
      logic [1:0] e;
      case (op)
         4'b1100, 4'b1101:                   e = 2'b10;
         4'b1000, 4'b1001, 4'b1010, 4'b1011: e = 2'b00;
         default:                            e = 2'b01;
      endcase
      return e;
   endfunction

   logic             out_valid_r;
   logic [XLEN-1:0]  out_instr_r;
   logic [XLEN-1:0]  out_pc_r;
   logic [IMM_W-1:0] out_imm_r;
   logic [1:0]       out_extop_r;
   logic             in_xfer_s;
   logic             load_out_s;
   logic [1:0]       in_extop_s;

   assign in_extop_s = extop_decode(in_instr[XLEN-1 -: 4]);
   assign load_out_s = !out_valid_r | out_ready;
   assign in_xfer_s  = in_valid & in_ready;

   assign out_valid  = out_valid_r;
   assign out_instr  = out_instr_r;
   assign out_pc     = out_pc_r;
   assign out_imm    = out_imm_r;
   assign out_extop  = out_extop_r;

`ifdef IF_ID_SKID_EN
   logic             skid_full_r;
   logic [XLEN-1:0]  skid_instr_r;
   logic [XLEN-1:0]  skid_pc_r;
   logic [IMM_W-1:0] skid_imm_r;
   logic [1:0]       skid_extop_r;

   // in_ready depends only on the skid flop, never on out_ready
   assign in_ready = !rst & !skid_full_r;

   // occupancy control: output register first, skid entry only while output is stalled
   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid_r <= 1'b0;
         skid_full_r <= 1'b0;
      end else if (flush) begin
         out_valid_r <= 1'b0;
         skid_full_r <= 1'b0;
      end else if (load_out_s) begin
         if (skid_full_r) begin
            out_valid_r <= 1'b1;
            skid_full_r <= 1'b0;
         end else begin
            out_valid_r <= in_xfer_s;
         end
      end else if (in_xfer_s) begin
         skid_full_r <= 1'b1;
      end else begin
         skid_full_r <= skid_full_r;
      end
   end

   // output payload: the older skid word drains before any new input
   always_ff @(posedge clk) begin
      if (rst) begin
         out_instr_r <= '0;
         out_pc_r    <= '0;
         out_imm_r   <= '0;
         out_extop_r <= 2'b00;
      end else if (!flush && load_out_s && skid_full_r) begin
         out_instr_r <= skid_instr_r;
         out_pc_r    <= skid_pc_r;
         out_imm_r   <= skid_imm_r;
         out_extop_r <= skid_extop_r;
      end else if (!flush && load_out_s && in_xfer_s) begin
         out_instr_r <= in_instr;
         out_pc_r    <= in_pc;
         out_imm_r   <= in_instr[IMM_W-1:0];
         out_extop_r <= in_extop_s;
      end else begin
         out_instr_r <= out_instr_r;
      end
   end

   // skid payload captures the word accepted while the output is stalled
   always_ff @(posedge clk) begin
      if (rst) begin
         skid_instr_r <= '0;
         skid_pc_r    <= '0;
         skid_imm_r   <= '0;
         skid_extop_r <= 2'b00;
      end else if (!flush && !load_out_s && in_xfer_s) begin
         skid_instr_r <= in_instr;
         skid_pc_r    <= in_pc;
         skid_imm_r   <= in_instr[IMM_W-1:0];
         skid_extop_r <= in_extop_s;
      end else begin
         skid_instr_r <= skid_instr_r;
      end
   end
`else
   logic out_xfer_s;

   assign out_xfer_s = out_valid_r & out_ready;
   assign in_ready   = !rst & load_out_s;

   // valid flag: flush beats input, input beats drain
   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid_r <= 1'b0;
      end else if (flush) begin
         out_valid_r <= 1'b0;
      end else if (in_xfer_s) begin
         out_valid_r <= 1'b1;
      end else if (out_xfer_s) begin
         out_valid_r <= 1'b0;
      end else begin
         out_valid_r <= out_valid_r;
      end
   end

   // payload loads only on an accepted, unflushed input
   always_ff @(posedge clk) begin
      if (rst) begin
         out_instr_r <= '0;
         out_pc_r    <= '0;
         out_imm_r   <= '0;
         out_extop_r <= 2'b00;
      end else if (in_xfer_s && !flush) begin
         out_instr_r <= in_instr;
         out_pc_r    <= in_pc;
         out_imm_r   <= in_instr[IMM_W-1:0];
         out_extop_r <= in_extop_s;
      end else begin
         out_instr_r <= out_instr_r;
      end
   end
`endif

endmodule

// File: tb/tb_if_id_stage.sv
// Directed/queue-model bench for if_id_stage (base or IF_ID_SKID_EN build).
module tb_if_id_stage;

   logic        clk = 1'b0;
   logic        rst, in_valid, in_ready, flush, out_valid, out_ready;
   logic [31:0] in_instr, in_pc, out_instr, out_pc;
   logic [23:0] out_imm;
   logic [1:0]  out_extop;

   int          vectors = 0;
   int          miscompares = 0;
   logic [31:0] q[$];
   logic [31:0] next_pc;

`ifdef IF_ID_SKID_EN
   localparam int CAP = 2;
`else
   localparam int CAP = 1;
`endif

   if_id_stage #(.XLEN(32), .IMM_W(24)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .in_instr(in_instr), .in_pc(in_pc), .flush(flush),
      .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
      .out_pc(out_pc), .out_imm(out_imm), .out_extop(out_extop)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      @(negedge clk);
   endtask

   function automatic logic [1:0] exp_extop(input logic [31:0] ins);
      logic [3:0] op;
      op = ins[31:28];
      if (op == 4'hC || op == 4'hD) return 2'b10;
      else if (op >= 4'h8 && op <= 4'hB) return 2'b00;
      else return 2'b01;
   endfunction

   function automatic logic [31:0] mk_instr(input logic [31:0] pc);
      return {pc[5:2], pc[27:0] ^ 28'h5A5A5A5};
   endfunction

   // one cycle against the queue model; the fetch side advances pc on each handshake
   task automatic cyc(input logic iv, input logic ordy, input logic fl);
      logic acc, dq;
      in_valid  = iv;
      out_ready = ordy;
      flush     = fl;
      in_pc     = iv ? next_pc : $urandom;
      in_instr  = iv ? mk_instr(next_pc) : $urandom;
      settle();
      chk("out_valid", {63'd0, out_valid}, {63'd0, q.size() != 0});
      if (CAP == 2) chk("in_ready", {63'd0, in_ready}, {63'd0, q.size() < 2});
      else          chk("in_ready", {63'd0, in_ready}, {63'd0, (q.size() == 0) || ordy});
      if (q.size() != 0) begin
         chk("out_pc", {32'd0, out_pc}, {32'd0, q[0]});
         chk("out_instr", {32'd0, out_instr}, {32'd0, mk_instr(q[0])});
         chk("out_imm", {40'd0, out_imm}, {40'd0, mk_instr(q[0]) & 32'h00FF_FFFF});
         chk("out_extop", {62'd0, out_extop}, {62'd0, exp_extop(mk_instr(q[0]))});
      end
      acc = iv & in_ready & !fl;
      dq  = out_valid & ordy & !fl;
      if (iv & in_ready) next_pc = next_pc + 32'd4;
      tick();
      if (fl) q.delete();
      else begin
         if (dq) void'(q.pop_front());
         if (acc) q.push_back(in_pc);
      end
      if (q.size() > CAP) chk("occupancy", 64'(q.size()), 64'(CAP));
   endtask

   initial begin
      // T1 reset with in_valid high
      rst = 1'b1; in_valid = 1'b1; out_ready = 1'b1; flush = 1'b0;
      in_pc = 32'h44; in_instr = 32'hC000_0001;
      tick(); tick();
      settle();
      chk("rst_valid", {63'd0, out_valid}, 64'd0);
      chk("rst_pc", {32'd0, out_pc}, 64'd0);
      chk("rst_instr", {32'd0, out_instr}, 64'd0);
      chk("rst_imm", {40'd0, out_imm}, 64'd0);
      chk("rst_extop", {62'd0, out_extop}, 64'd0);
      chk("rst_in_ready", {63'd0, in_ready}, 64'd0);
      rst = 1'b0; in_valid = 1'b0;
      #1;
      chk("post_rst_in_ready", {63'd0, in_ready}, 64'd1);
      tick();

      // T2 extop/immediate decode
      in_valid = 1'b1; in_pc = 32'h10; in_instr = 32'hC012_3456;
      settle();
      chk("t2_in_ready", {63'd0, in_ready}, 64'd1);
      tick();
      in_pc = 32'h14; in_instr = 32'h8000_FFFF;
      settle();
      chk("t2a_valid", {63'd0, out_valid}, 64'd1);
      chk("t2a_extop", {62'd0, out_extop}, 64'd2);
      chk("t2a_imm", {40'd0, out_imm}, 64'h123456);
      chk("t2a_pc", {32'd0, out_pc}, 64'h10);
      tick();
      in_pc = 32'h18; in_instr = 32'h1234_ABCD;
      settle();
      chk("t2b_extop", {62'd0, out_extop}, 64'd0);
      chk("t2b_imm", {40'd0, out_imm}, 64'h00FFFF);
      chk("t2b_instr", {32'd0, out_instr}, 64'h8000_FFFF);
      tick();
      in_valid = 1'b0;
      settle();
      chk("t2c_extop", {62'd0, out_extop}, 64'd1);
      chk("t2c_imm", {40'd0, out_imm}, 64'h34ABCD);
      chk("t2c_pc", {32'd0, out_pc}, 64'h18);
      tick();
      settle();
      chk("t2_drained", {63'd0, out_valid}, 64'd0);
      tick();

      // T3 stall with in_valid held, then release
      next_pc = 32'h100;
      cyc(1'b1, 1'b1, 1'b0);
      for (int i = 0; i < 5; i++) cyc(1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) cyc(1'b1, 1'b1, 1'b0);
      for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, 1'b0);

      // T4 flush drops held words and the same-cycle input
      next_pc = 32'h1F0;
      cyc(1'b1, 1'b1, 1'b0);
      cyc(1'b1, 1'b0, 1'b0);
      next_pc = 32'h200;
      cyc(1'b1, 1'b0, 1'b1);
      cyc(1'b0, 1'b1, 1'b0);
      next_pc = 32'h300;
      for (int i = 0; i < 3; i++) cyc(1'b1, 1'b1, 1'b0);
      for (int i = 0; i < 2; i++) cyc(1'b0, 1'b1, 1'b0);

      // T5 streaming 0x0..0x3C
      next_pc = 32'h0;
      for (int i = 0; i < 16; i++) cyc(1'b1, 1'b1, 1'b0);
      for (int i = 0; i < 2; i++) cyc(1'b0, 1'b1, 1'b0);

      // T6 random handshake and flush
      next_pc = 32'h1000;
      for (int i = 0; i < 10000; i++)
         cyc($urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0, $urandom_range(0, 31) == 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
